// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipe_reg_chain elastic pipeline.
package pipe_reg_chain_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_reg_stage: one elastic register stage with valid/ready on both sides.
// Data only moves on load, so a stalled word stays stable.
module pipe_reg_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // An empty stage accepts regardless of downstream, which collapses bubbles.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o && !flush_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH elastic stages with synchronous flush.
// Define PIPE_REG_CHAIN_OCC_EN to add the registered occupancy port.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             vld_in, rdy_in, vld_out, rdy_out;
    logic [WIDTH-1:0] dat_in, dat_out;

    if (gi == 0) begin : g_head
      assign vld_in = in_valid;
      assign dat_in = in_data;
    end else begin : g_link
      assign vld_in = g_stage[gi-1].vld_out;
      assign dat_in = g_stage[gi-1].dat_out;
    end

    // Backward ready chain: combinational from out_ready to in_ready.
    if (gi == DEPTH - 1) begin : g_tail
      assign rdy_out = out_ready;
    end else begin : g_next
      assign rdy_out = g_stage[gi+1].rdy_in;
    end

    pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .in_valid_i  (vld_in),
      .in_ready_o  (rdy_in),
      .in_data_i   (dat_in),
      .out_valid_o (vld_out),
      .out_ready_i (rdy_out),
      .out_data_o  (dat_out)
    );
  end

  // Flush blocks transfers on both sides during its cycle.
  assign in_ready  = g_stage[0].rdy_in && !flush;
  assign out_valid = g_stage[DEPTH-1].vld_out && !flush;
  assign out_data  = g_stage[DEPTH-1].dat_out;

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_xfer, out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end
`else
  // No occupancy tracking in this build.
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed table-driven bench for pipe_reg_chain (WIDTH=32, DEPTH=3).
module tb_pipe_reg_chain;
  import pipe_reg_chain_pkg::*;

  localparam int W = 32;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [occ_width(D)-1:0] occupancy;
`endif

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    int           e_occ;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [W-1:0] e_od, input int e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_occ(input string name, input int exp);
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk(name, W'(occupancy), W'(exp));
`else
    if (exp < 0) $display("note %s: occupancy not built", name);
`endif
  endtask

  initial begin
    // iv  data   ordy fl | in_ready out_valid out_data occ
    add(1, 32'h1,  1, 0,   1, 0, 32'h0,  0);  // streaming
    add(1, 32'h2,  1, 0,   1, 0, 32'h0,  1);
    add(1, 32'h3,  1, 0,   1, 0, 32'h0,  2);
    add(0, 32'h0,  1, 0,   1, 1, 32'h1,  3);
    add(0, 32'h0,  1, 0,   1, 1, 32'h2,  2);
    add(0, 32'h0,  1, 0,   1, 1, 32'h3,  1);
    add(1, 32'hA,  0, 0,   1, 0, 32'h3,  0);  // backpressure fill
    add(1, 32'hB,  0, 0,   1, 0, 32'h3,  1);
    add(1, 32'hC,  0, 0,   1, 0, 32'h3,  2);
    add(1, 32'hD,  0, 0,   0, 1, 32'hA,  3);  // full: refuse
    add(1, 32'hD,  1, 0,   1, 1, 32'hA,  3);  // full + simultaneous transfer
    add(0, 32'h0,  1, 0,   1, 1, 32'hB,  3);
    add(0, 32'h0,  1, 0,   1, 1, 32'hC,  2);
    add(0, 32'h0,  1, 0,   1, 1, 32'hD,  1);
    add(0, 32'h0,  1, 0,   1, 0, 32'hD,  0);  // empty: data holds
    add(1, 32'hE,  0, 0,   1, 0, 32'hD,  0);  // bubble collapse setup
    add(0, 32'h0,  0, 0,   1, 0, 32'hD,  1);
    add(0, 32'h0,  0, 0,   1, 0, 32'hD,  1);
    add(1, 32'hF,  0, 0,   1, 1, 32'hE,  1);  // two consecutive accepts
    add(1, 32'h10, 0, 0,   1, 1, 32'hE,  2);
    add(1, 32'h11, 0, 0,   0, 1, 32'hE,  3);
    add(0, 32'h0,  1, 0,   1, 1, 32'hE,  3);
    add(1, 32'h11, 1, 1,   0, 0, 32'hF,  2);  // flush with 2 held
    add(1, 32'h55, 1, 0,   1, 0, 32'hF,  0);
    add(0, 32'h0,  1, 0,   1, 0, 32'hF,  1);
    add(0, 32'h0,  1, 0,   1, 0, 32'hF,  1);
    add(0, 32'h0,  1, 0,   1, 1, 32'h55, 1);

    // Reset held 2 cycles with in_valid high.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    $display("reset release: in_ready=%0b out_valid=%0b out_data=0x%0h", in_ready, out_valid, out_data);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk_occ("rst_occ", 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy; flush = tbl[i].fl;
      @(negedge clk);
      $display("vec %0d: iv=%0b id=0x%0h or=%0b fl=%0b -> ir=%0b ov=%0b od=0x%0h",
               i, in_valid, in_data, out_ready, flush, in_ready, out_valid, out_data);
      chk($sformatf("v%0d_in_ready", i), W'(in_ready), W'(tbl[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), W'(out_valid), W'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      chk_occ($sformatf("v%0d_occ", i), tbl[i].e_occ);
    end

    // Reset mid-stream: two words in flight are discarded.
    @(posedge clk); #1 in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1 in_data = 32'h88;
    @(posedge clk); #1 in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    $display("mid-stream reset: ov=%0b od=0x%0h ir=%0b", out_valid, out_data, in_ready);
    chk("mrst_out_valid", W'(out_valid), W'(0));
    chk("mrst_out_data", out_data, 32'h0);
    chk("mrst_in_ready", W'(in_ready), W'(1));
    chk_occ("mrst_occ", 0);
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      $display("post-reset idle %0d: ov=%0b", k, out_valid);
      chk($sformatf("mrst_idle%0d_out_valid", k), W'(out_valid), W'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
